prog_mem_ctrl: RTL and testbench
================================

Name: prog_mem_ctrl

Overview:
- Parametrised, byte-addressed, little-endian program/data memory with a request/response port for the core.
- Adds behaviour the previous program memory lacks: byte-enable writes, registered 1-cycle reads, a post-reset fill sweep, and a streaming byte-load (bootload) port.
- Sits between the RV32I core fetch/LSU path and the UART bootloader.
- Replaces hard-coded initial-block program images with runtime loading.

Parameters:
- ADDR_W, 15: byte-address width; depth = 2^ADDR_W bytes.
- DATA_W, 32: access width; multiple of 8. NB = DATA_W/8 byte lanes.
- FILL, 8'hFF: value written to every byte by the post-reset fill sweep.

Ports:
- clk  in  1  rising-edge clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE; a request transfers when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  NB  byte-lane enables (writes only).
- req_addr  in  ADDR_W  byte address of lane 0.
- req_wdata  in  DATA_W  write data; lane k = bits [8k+7:8k].
- rsp_valid  out  1  one-cycle pulse, one cycle after every accepted request (read or write).
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads; 0 on writes.
- rsp_err  out  1  with rsp_valid: access wrapped past the top address.
- ld_start  in  1  enter LOAD state (sampled in IDLE only).
- ld_valid  in  1  load byte strobe.
- ld_byte  in  8  byte to store.
- ld_done  in  1  leave LOAD state.
- ld_count  out  ADDR_W+1  bytes written in the current/last load; saturates at 2^ADDR_W.
- busy  out  1  high in CLEAR or LOAD.

Behaviour:
- Reset (rst_n low at posedge):
  - state <= CLEAR; fill pointer <= 0; ld_count <= 0.
  - req_ready, rsp_valid, rsp_err, busy, rsp_rdata <= 0.
  - Reset mid-LOAD or mid-CLEAR restarts the CLEAR sweep; partially loaded data is overwritten.
- CLEAR:
  - Writes FILL to NB bytes per cycle at fill pointer*NB; pointer increments.
  - After the last word (2^ADDR_W/NB cycles) -> IDLE.
  - busy=1, req_ready=0. ld_start and ld_valid are ignored.
- IDLE:
  - req_ready=1, busy=0.
  - Accepted read: rsp_rdata lane k <= mem[(req_addr+k) mod 2^ADDR_W], registered; rsp_valid=1 the next cycle. Unaligned addresses are legal.
  - Accepted write: for each k with req_be[k]=1, mem[(req_addr+k) mod 2^ADDR_W] <= lane k at the same posedge; rsp_valid=1 the next cycle.
  - A read issued the cycle after a write to the same bytes returns the new data.
  - Back-to-back requests every cycle are allowed (throughput 1/cycle).
  - rsp_err=1 iff req_addr+NB-1 > 2^ADDR_W-1. The access still completes with wrapped addresses.
  - ld_start with no accepted request in the same cycle -> LOAD, load pointer <= 0, ld_count <= 0.
  - If req_valid and ld_start are both high, the request is accepted and ld_start is ignored.
- LOAD:
  - busy=1, req_ready=0.
  - Each ld_valid writes ld_byte at the load pointer; pointer increments mod 2^ADDR_W; ld_count increments, saturating at 2^ADDR_W.
  - ld_done -> IDLE next cycle. If ld_valid and ld_done are both high, the byte is written, then the state exits.
  - ld_count holds its value in IDLE until the next ld_start.
- rsp_valid for the last request accepted in IDLE still fires the cycle after acceptance, even if the state has changed.

Test Plan:
- ADDR_W=8: release reset, count 64 cycles -> busy drops on cycle 64; read addr 0x10 -> 32'hFFFFFFFF; rsp_valid exactly 1 cycle after acceptance.
- Write 32'h000F_F137 at 0x08, be=4'b1111; read 0x08 -> 32'h000F_F137; read 0x09 -> 32'hFF00_0FF1 (little-endian, unaligned).
- Write 32'hAABBCCDD at 0x20 with be=4'b0101; read 0x20 -> 32'hFFBBFFDD. Then write be=4'b0000 -> memory unchanged.
- Read at 0xFE -> rsp_err=1; data = {mem[0x01], mem[0x00], mem[0xFF], mem[0xFE]}. Read at 0xFC -> rsp_err=0.
- ld_start, stream bytes B7,10,00,00,93,80,80,00, ld_done with the last byte -> ld_count=8; read 0x00 -> 32'h000010B7, read 0x04 -> 32'h00808093; req_ready=0 throughout LOAD.
- Assert rst_n low after 3 load bytes -> CLEAR restarts; after the sweep, read 0x00 -> 32'hFFFFFFFF and ld_count=0.

Source files
------------

// File: rtl/prog_mem_ctrl.sv
// -----------------------------------------------------------------------------
// prog_mem_ctrl
//
// Byte-addressed, little-endian program/data memory for the RV32I core, with a
// streaming byte-load port fed by the UART bootloader. After reset the whole
// array is swept to FILL before the core may access it.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   core request handshake (ready only when IDLE)
//   req_we            1 = write, 0 = read
//   req_be            byte-lane enables for writes
//   req_addr          byte address of lane 0 (unaligned allowed, wraps)
//   req_wdata         write data, lane k = bits [8k+7:8k]
//   rsp_valid         one-cycle pulse the cycle after every accepted request
//   rsp_rdata         read data (0 for writes)
//   rsp_err           access ran past the top address and wrapped
//   ld_start          enter LOAD from IDLE
//   ld_valid/ld_byte  bootload byte strobe and data
//   ld_done           leave LOAD
//   ld_count          bytes written by the current/last load (saturating)
//   busy              high while clearing or loading
//
// DATA_W/8 is expected to be a power of two so the fill sweep tiles the array.
// -----------------------------------------------------------------------------
module prog_mem_ctrl #(
    parameter int         ADDR_W = 15,
    parameter int         DATA_W = 32,
    parameter logic [7:0] FILL   = 8'hFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    input  logic                ld_start,
    input  logic                ld_valid,
    input  logic [7:0]          ld_byte,
    input  logic                ld_done,
    output logic [ADDR_W:0]     ld_count,
    output logic                busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(DEPTH - NB);
    localparam logic [ADDR_W:0]   LD_MAX    = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_LOAD
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] fill_addr;  // byte address of the word being filled
    logic [ADDR_W-1:0] ld_ptr;
    logic              accept;
    logic [ADDR_W:0]   end_addr;   // one extra bit to detect the wrap

    // req_ready is registered and high exactly when the state is IDLE,
    // so it alone qualifies the handshake.
    assign accept   = req_valid && req_ready;
    assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(NB - 1);

    // -------------------------------------------------------------------------
    // Control FSM and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: the reset is synchronous, so it is tested inside the clocked block
    // rather than listed in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_CLEAR;
            fill_addr <= '0;
            ld_ptr    <= '0;
            ld_count  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            // The response path depends only on acceptance, so a response
            // still fires even if the state moves on in the same cycle.
            rsp_valid <= accept;
            rsp_err   <= accept && end_addr[ADDR_W];
            if (accept) begin
                if (req_we) begin
                    rsp_rdata <= '0;
                end else begin
                    for (int k = 0; k < NB; k++) begin
                        rsp_rdata[8*k +: 8] <= mem[req_addr + ADDR_W'(k)];
                    end
                end
            end

            case (state)
                S_CLEAR: begin
                    fill_addr <= fill_addr + ADDR_W'(NB);
                    if (fill_addr == FILL_LAST) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                S_IDLE: begin
                    // An accepted request takes priority over ld_start.
                    if (ld_start && !accept) begin
                        state     <= S_LOAD;
                        ld_ptr    <= '0;
                        ld_count  <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (ld_valid) begin
                        ld_ptr <= ld_ptr + ADDR_W'(1);
                        if (ld_count != LD_MAX) begin
                            ld_count <= ld_count + (ADDR_W+1)'(1);
                        end
                    end
                    if (ld_done) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                default: begin
                    state     <= S_CLEAR;
                    fill_addr <= '0;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Byte array: exactly one write source is active per state.
    // -------------------------------------------------------------------------
    // NOTE: the array itself has no reset; its contents are defined by the
    // CLEAR sweep that every reset starts. Writes are only suppressed while
    // rst_n is low so a reset mid-load cannot store a stray byte.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            case (state)
                S_CLEAR: begin
                    for (int k = 0; k < NB; k++) begin
                        mem[fill_addr + ADDR_W'(k)] <= FILL;
                    end
                end
                S_IDLE: begin
                    if (accept && req_we) begin
                        for (int k = 0; k < NB; k++) begin
                            if (req_be[k]) begin
                                mem[req_addr + ADDR_W'(k)] <= req_wdata[8*k +: 8];
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        mem[ld_ptr] <= ld_byte;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prog_mem_ctrl
//
// Bench for prog_mem_ctrl at ADDR_W=8, DATA_W=32. Expected values come from a
// plain byte-array model of the memory, from a directed vector table, and from
// hand sequences for clear timing, bootloading and reset during a load.
// -----------------------------------------------------------------------------
module tb_prog_mem_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [NB-1:0] req_be;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          ld_start;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_done;
    logic [AW:0]   ld_count;
    logic          busy;

    prog_mem_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .FILL   (8'hFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_byte   (ld_byte),
        .ld_done   (ld_done),
        .ld_count  (ld_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference memory: one byte per address, wrap by modulo.
    logic [7:0] model_mem [DEPTH];

    typedef struct {
        string         name;
        logic          we;
        logic [NB-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_fill();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hFF;
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = model_mem[(int'(a) + k) % DEPTH];
        return r;
    endfunction

    function automatic logic model_err(input logic [AW-1:0] a);
        return (int'(a) + NB - 1) > (DEPTH - 1);
    endfunction

    // One request, accepted at the next edge; response sampled one cycle later
    // (just after that edge). Leaves req_valid low so the caller may follow
    // with another request without an idle cycle.
    task automatic do_req(input logic we, input logic [NB-1:0] be,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          output logic vld, output logic [DW-1:0] rd,
                          output logic err);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        vld = rsp_valid;
        rd  = rsp_rdata;
        err = rsp_err;
        req_valid = 1'b0;
        if (we) begin
            for (int k = 0; k < NB; k++) begin
                if (be[k]) model_mem[(int'(addr) + k) % DEPTH] = wdata[8*k +: 8];
            end
        end
    endtask

    // Counts cycles after reset release until busy drops; bounded.
    task automatic wait_clear(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (busy && cyc < 200);
    endtask

    task automatic add_vec(input string name, input logic we, input logic [NB-1:0] be,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int            cyc;
        logic          vld;
        logic [DW-1:0] rd;
        logic          err;
        logic          we;
        logic [NB-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        logic [7:0]    boot [8];

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = '0;
        req_addr = '0; req_wdata = '0; ld_start = 1'b0; ld_valid = 1'b0;
        ld_byte = '0; ld_done = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_ld_count",  32'(ld_count), 0);

        // ---------------- clear sweep timing ----------------
        rst_n = 1'b1;
        tick();
        check("clear_busy_c1",  32'(busy), 1);
        check("clear_ready_c1", 32'(req_ready), 0);
        cyc = 1;
        while (busy && cyc < 200) begin
            tick();
            cyc++;
        end
        check("clear_cycles", 32'(cyc), 64);
        check("clear_ready",  32'(req_ready), 1);
        model_fill();

        do_req(1'b0, '0, 8'h10, '0, vld, rd, err);
        check("first_rd_valid", 32'(vld), 1);
        check("first_rd_data",  rd, 32'hFFFF_FFFF);
        tick();
        check("rsp_pulse_one_cycle", 32'(rsp_valid), 0);

        // ---------------- directed table, issued back to back ----------------
        add_vec("wr_08",       1, 4'hF, 8'h08, 32'h000F_F137, 32'h0,          0);
        add_vec("rd_08",       0, 4'h0, 8'h08, 32'h0,         32'h000F_F137,  0);
        add_vec("rd_09_unal",  0, 4'h0, 8'h09, 32'h0,         32'hFF00_0FF1,  0);
        add_vec("wr_20_be5",   1, 4'h5, 8'h20, 32'hAABB_CCDD, 32'h0,          0);
        add_vec("rd_20",       0, 4'h0, 8'h20, 32'h0,         32'hFFBB_FFDD,  0);
        add_vec("wr_20_be0",   1, 4'h0, 8'h20, 32'h1234_5678, 32'h0,          0);
        add_vec("rd_20_again", 0, 4'h0, 8'h20, 32'h0,         32'hFFBB_FFDD,  0);
        add_vec("wr_fe_wrap",  1, 4'hF, 8'hFE, 32'h4433_2211, 32'h0,          1);
        add_vec("rd_fe_wrap",  0, 4'h0, 8'hFE, 32'h0,         32'h4433_2211,  1);
        add_vec("rd_fc_top",   0, 4'h0, 8'hFC, 32'h0,         32'h2211_FFFF,  0);
        add_vec("rd_fd_wrap",  0, 4'h0, 8'hFD, 32'h0,         32'h3322_11FF,  1);
        add_vec("rd_00_wrap",  0, 4'h0, 8'h00, 32'h0,         32'hFFFF_4433,  0);

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vld, rd, err);
            check({vecs[i].name, "_valid"}, 32'(vld), 1);
            check({vecs[i].name, "_data"},  rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"},   32'(err), 32'(vecs[i].exp_err));
        end
        tick();

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < 300; i++) begin
            we   = 1'($urandom);
            be   = NB'($urandom);
            addr = ($urandom % 2 == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            wd   = $urandom;
            exp_rd  = we ? '0 : model_read(addr);
            exp_err = model_err(addr);
            do_req(we, be, addr, wd, vld, rd, err);
            check("rnd_valid", 32'(vld), 1);
            check("rnd_data",  rd, exp_rd);
            check("rnd_err",   32'(err), 32'(exp_err));
            if ($urandom % 4 == 0) begin
                tick();
                check("rnd_idle_valid", 32'(rsp_valid), 0);
            end
        end
        tick();

        // ---------------- bootload of a short program ----------------
        boot = '{8'hB7, 8'h10, 8'h00, 8'h00, 8'h93, 8'h80, 8'h80, 8'h00};
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("ld_busy",  32'(busy), 1);
        check("ld_ready", 32'(req_ready), 0);
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1;
            ld_byte  = boot[i];
            ld_done  = (i == 7);
            req_valid = 1'b1;  // must be ignored while loading
            req_we = 1'b1; req_be = 4'hF; req_addr = 8'h00; req_wdata = 32'hDEAD_BEEF;
            tick();
            model_mem[i] = boot[i];
            if (i < 7) begin
                check("ld_ready_low",  32'(req_ready), 0);
                check("ld_no_rsp",     32'(rsp_valid), 0);
            end
        end
        req_valid = 1'b0; ld_valid = 1'b0; ld_done = 1'b0;
        check("ld_count_8",   32'(ld_count), 8);
        check("ld_exit_busy", 32'(busy), 0);
        check("ld_exit_rdy",  32'(req_ready), 1);
        do_req(1'b0, '0, 8'h00, '0, vld, rd, err);
        check("boot_rd_00", rd, 32'h0000_10B7);
        do_req(1'b0, '0, 8'h04, '0, vld, rd, err);
        check("boot_rd_04", rd, 32'h0080_8093);

        // ld_start together with a request: request wins, state stays IDLE
        ld_start = 1'b1;
        do_req(1'b0, '0, 8'h04, '0, vld, rd, err);
        ld_start = 1'b0;
        check("coll_valid", 32'(vld), 1);
        check("coll_busy",  32'(busy), 0);
        check("coll_ready", 32'(req_ready), 1);
        check("coll_count_hold", 32'(ld_count), 8);

        // ---------------- long load: wrap and count saturation ----------------
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("ld2_count_zero", 32'(ld_count), 0);
        for (int i = 0; i < DEPTH + 4; i++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'($urandom);
            ld_done  = (i == DEPTH + 3);
            model_mem[i % DEPTH] = ld_byte;
            tick();
        end
        ld_valid = 1'b0; ld_done = 1'b0;
        check("ld2_count_sat", 32'(ld_count), DEPTH);
        for (int i = 0; i < 6; i++) begin
            addr = (i < 3) ? AW'(i * 2) : AW'($urandom);
            exp_rd = model_read(addr);
            do_req(1'b0, '0, addr, '0, vld, rd, err);
            check("ld2_rd", rd, exp_rd);
        end
        tick();

        // ---------------- reset during a load ----------------
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'h5A + 8'(i);
            tick();
        end
        check("mid_ld_count", 32'(ld_count), 3);
        rst_n = 1'b0;
        tick();
        ld_valid = 1'b0;
        check("mid_rst_count", 32'(ld_count), 0);
        rst_n = 1'b1;
        wait_clear(cyc);
        check("mid_rst_clear_cycles", 32'(cyc), 64);
        model_fill();
        do_req(1'b0, '0, 8'h00, '0, vld, rd, err);
        check("mid_rst_rd_00", rd, 32'hFFFF_FFFF);
        check("mid_rst_ld_count", 32'(ld_count), 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
